// File: rtl/cic_decimator_pkg.sv
// Shared DFE receive-chain constants and types for the CIC decimator.
package cic_decimator_pkg;

    localparam int unsigned DATA_WIDTH     = 16;
    localparam int unsigned CIC_STAGES     = 5;
    localparam int unsigned CIC_MAX_LOG2_D = 4;
    // Register growth is STAGES * log2(Dmax) bits with differential delay M = 1.
    localparam int unsigned ACC_WIDTH      = DATA_WIDTH + CIC_STAGES * CIC_MAX_LOG2_D;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef logic signed [ACC_WIDTH-1:0]  acc_t;

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb stage: a delay register and a modular subtractor.
module cic_comb_stage #(
    parameter int unsigned ACC_WIDTH = cic_decimator_pkg::ACC_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 en,
    input  logic                 clr,
    input  logic [ACC_WIDTH-1:0] din,
    output logic [ACC_WIDTH-1:0] dout
);
    import cic_decimator_pkg::*;

    logic [ACC_WIDTH-1:0] z;

    // Delay register captures the stage input on each decimated step.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            z <= '0;
        end else if (clr) begin
            z <= '0;
        end else if (en) begin
            z <= din;
        end
    end

    // Wrap-around is intended; the cascade is exact modulo 2^ACC_WIDTH.
    assign dout = din - z;

endmodule

// File: rtl/cic_decimator.sv
// Five-stage CIC decimator, D = 2^log2_d in {1..16}, unity-gain 16-bit output.
module cic_decimator #(
    parameter int unsigned DATA_WIDTH = cic_decimator_pkg::DATA_WIDTH,
    parameter int unsigned STAGES     = cic_decimator_pkg::CIC_STAGES,
    parameter int unsigned MAX_LOG2_D = cic_decimator_pkg::CIC_MAX_LOG2_D,
    parameter int unsigned ACC_WIDTH  = DATA_WIDTH + STAGES * MAX_LOG2_D
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic signed [DATA_WIDTH-1:0] x_n,
    input  logic                         valid_in,
    input  logic                         EN,
    input  logic                         bypass,
    input  logic [2:0]                   log2_d,
    output logic signed [DATA_WIDTH-1:0] y_m,
    output logic                         valid
);
    import cic_decimator_pkg::*;

    localparam int unsigned CNT_WIDTH = MAX_LOG2_D + 1;

    logic                         run;
    logic                         accept;
    logic                         reconf;
    logic [2:0]                   l2d_sel;
    logic [2:0]                   l2d_q;
    logic [MAX_LOG2_D-1:0]        cnt;
    logic [CNT_WIDTH-1:0]         d_last;
    logic                         cnt_last;
    logic                         dec_stb;
    logic                         comb_en;
    logic [ACC_WIDTH-1:0]         x_ext;
    logic [ACC_WIDTH-1:0]         integ  [STAGES];
    logic [ACC_WIDTH-1:0]         comb_c [STAGES+1];
    logic signed [ACC_WIDTH-1:0]  comb_out;
    int unsigned                  shamt;
    logic [DATA_WIDTH-1:0]        y_scaled;

    assign run      = EN & ~bypass;
    assign accept   = valid_in & run;
    assign l2d_sel  = (log2_d > 3'(MAX_LOG2_D)) ? 3'(MAX_LOG2_D) : log2_d;
    // A changed decimation select restarts the filter from a clean state.
    assign reconf   = EN & (l2d_sel != l2d_q);
    assign d_last   = (CNT_WIDTH'(1) << l2d_q) - CNT_WIDTH'(1);
    assign cnt_last = ({1'b0, cnt} == d_last);
    assign comb_en  = run & dec_stb;
    assign x_ext    = {{(ACC_WIDTH-DATA_WIDTH){x_n[DATA_WIDTH-1]}}, x_n};

    // Decimation counter, group strobe and registered decimation select.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt     <= '0;
            dec_stb <= 1'b0;
            l2d_q   <= '0;
        end else if (reconf) begin
            cnt     <= '0;
            dec_stb <= 1'b0;
            l2d_q   <= l2d_sel;
        end else if (run) begin
            dec_stb <= accept & cnt_last;
            if (accept) begin
                cnt <= cnt_last ? '0 : cnt + MAX_LOG2_D'(1);
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_integ
        logic [ACC_WIDTH-1:0] acc;
        logic [ACC_WIDTH-1:0] add;
        if (k == 0) begin : g_first
            assign add = x_ext;
        end else begin : g_next
            assign add = integ[k-1];
        end
        // Integrator k accumulates the pre-edge value of its predecessor.
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                acc <= '0;
            end else if (reconf) begin
                acc <= '0;
            end else if (accept) begin
                acc <= acc + add;
            end
        end
        assign integ[k] = acc;
    end

    assign comb_c[0] = integ[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_comb
        cic_comb_stage #(
            .ACC_WIDTH (ACC_WIDTH)
        ) u_comb (
            .CLK  (CLK),
            .RST  (RST),
            .en   (comb_en),
            .clr  (reconf),
            .din  (comb_c[k]),
            .dout (comb_c[k+1])
        );
    end

    // Gain is D^STAGES, so dividing by 2^(STAGES*log2_d) gives exact unity DC gain.
    assign comb_out = comb_c[STAGES];
    assign shamt    = STAGES * 32'(l2d_q);
    assign y_scaled = DATA_WIDTH'(comb_out >>> shamt);

    // Output register: normal, bypass, disabled and reconfiguration behaviour.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            y_m   <= '0;
            valid <= 1'b0;
        end else if (reconf) begin
            valid <= 1'b0;
        end else if (EN && bypass) begin
            y_m   <= x_n;
            valid <= valid_in;
        end else if (EN) begin
            valid <= dec_stb;
            if (dec_stb) begin
                y_m <= y_scaled;
            end
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator against a direct-form CIC reference.
module tb_cic_decimator;

    logic               CLK = 1'b0;
    logic               RST = 1'b0;
    logic signed [15:0] x_n = '0;
    logic               valid_in = 1'b0;
    logic               EN = 1'b0;
    logic               bypass = 1'b0;
    logic [2:0]         log2_d = '0;
    logic signed [15:0] y_m;
    logic               valid;

    int errors = 0;
    int checks = 0;

    cic_decimator dut (
        .CLK      (CLK),
        .RST      (RST),
        .x_n      (x_n),
        .valid_in (valid_in),
        .EN       (EN),
        .bypass   (bypass),
        .log2_d   (log2_d),
        .y_m      (y_m),
        .valid    (valid)
    );

    always #5 CLK = ~CLK;

    // Reference: output = decimated 5-fold boxcar of the input delayed by the
    // four-sample integrator pipeline, divided by D^5 (floor).
    typedef struct {
        logic signed [15:0] value;
        int                 at;
    } exp_t;

    int                 hist[$];
    longint             h[$];
    int                 m_l2d = 0;
    exp_t               expq[$];
    int                 cyc = 0;
    logic               obs_valid;
    logic signed [15:0] obs_y;

    function automatic void build_h(int l2d);
        longint cur[$];
        longint nxt[$];
        int d = 1 << l2d;
        cur.push_back(1);
        for (int s = 0; s < 5; s++) begin
            nxt.delete();
            for (int i = 0; i < cur.size() + d - 1; i++) nxt.push_back(0);
            for (int i = 0; i < cur.size(); i++)
                for (int j = 0; j < d; j++) nxt[i+j] += cur[i];
            cur = nxt;
        end
        h = cur;
    endfunction

    function automatic logic signed [15:0] cic_expect();
        longint acc = 0;
        int n = hist.size() - 1;
        for (int i = 0; i < h.size(); i++) begin
            int idx = n - 4 - i;
            if (idx >= 0) acc += h[i] * longint'(hist[idx]);
        end
        acc = acc >>> (5 * m_l2d);
        return acc[15:0];
    endfunction

    function automatic void model_clear();
        hist.delete();
        expq.delete();
    endfunction

    // Advance one clock, apply the block's rules to the model, sample outputs.
    task automatic tick();
        int   sel;
        exp_t e;
        sel = (log2_d > 3'd4) ? 4 : int'(log2_d);
        @(posedge CLK);
        cyc++;
        if (RST) begin
            if (EN && sel != m_l2d) begin
                model_clear();
                m_l2d = sel;
                build_h(sel);
            end else if (EN && !bypass && valid_in) begin
                hist.push_back(int'(x_n));
                if (hist.size() % (1 << m_l2d) == 0) begin
                    e.value = cic_expect();
                    e.at    = cyc;
                    expq.push_back(e);
                end
            end
        end
        #1;
        obs_valid = valid;
        obs_y     = y_m;
    endtask

    task automatic test_reset();
        exp_t e;
        EN = 1'b1;
        log2_d = 3'd2;
        for (int i = 0; i < 3; i++) begin
            valid_in = i[0];
            x_n = 16'($urandom);
            tick();
            checks++;
            if (obs_y !== 16'sd0 || obs_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: y_m=%0d valid=%b, required 0/0", obs_y, obs_valid);
            end
        end
        RST = 1'b1;
        x_n = '0;
        for (int i = 0; i < 60; i++) begin
            valid_in = 1'b1;
            tick();
            if (obs_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL reset_spurious: valid=1 y_m=%0d, required valid=0", obs_y);
                end else begin
                    e = expq.pop_front();
                    if (obs_y !== 16'sd0 || e.value !== 16'sd0) begin
                        errors++;
                        $display("FAIL reset_zero: y_m=%0d, required 0", obs_y);
                    end
                end
            end
        end
        valid_in = 1'b0;
        repeat (3) begin
            tick();
            if (obs_valid && expq.size() != 0) void'(expq.pop_front());
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL reset_drain: %0d outputs missing, required 0", expq.size());
        end
    endtask

    task automatic test_dc_d4();
        exp_t e;
        int   nout = 0;
        log2_d = 3'd2;
        valid_in = 1'b0;
        tick();
        for (int i = 0; i < 400; i++) begin
            valid_in = (i % 2 == 0);
            x_n = valid_in ? 16'sd1000 : 16'($urandom);
            tick();
            if (obs_valid) begin
                checks++;
                nout++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL dc4_spurious: valid=1 y_m=%0d, required valid=0", obs_y);
                end else begin
                    e = expq.pop_front();
                    if (obs_y !== e.value || cyc != e.at + 1) begin
                        errors++;
                        $display("FAIL dc4_out: y_m=%0d at cycle %0d, required %0d at cycle %0d",
                                 obs_y, cyc, e.value, e.at + 1);
                    end
                    if (nout >= 8 && obs_y !== 16'sd1000) begin
                        errors++;
                        $display("FAIL dc4_settled: y_m=%0d, required 1000", obs_y);
                    end
                end
            end
        end
        checks++;
        if (nout != 50 || expq.size() != 0) begin
            errors++;
            $display("FAIL dc4_count: %0d outputs (%0d pending), required 50", nout, expq.size());
        end
    endtask

    task automatic test_extremes();
        exp_t               e;
        logic signed [15:0] last_y;
        logic signed [15:0] level [2];
        level[0] = -16'sd32768;
        level[1] = 16'sd32767;
        for (int p = 0; p < 2; p++) begin
            int ns = 0;
            log2_d = (p == 0) ? 3'd4 : 3'd7;
            valid_in = 1'b0;
            tick();
            while (ns < 400 || expq.size() != 0) begin
                valid_in = (ns < 400) && ($urandom_range(0, 2) != 0);
                x_n = level[p];
                if (valid_in) ns++;
                tick();
                if (obs_valid) begin
                    checks++;
                    last_y = obs_y;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL ext_spurious: valid=1 y_m=%0d, required valid=0", obs_y);
                    end else begin
                        e = expq.pop_front();
                        if (obs_y !== e.value) begin
                            errors++;
                            $display("FAIL ext_out: y_m=%0d, required %0d", obs_y, e.value);
                        end
                    end
                end
                if (cyc > 20000) begin
                    errors++;
                    $display("FAIL ext_timeout: %0d outputs never appeared", expq.size());
                    expq.delete();
                end
            end
            checks++;
            if (last_y !== level[p]) begin
                errors++;
                $display("FAIL ext_settled: y_m=%0d, required %0d", last_y, level[p]);
            end
        end
    endtask

    task automatic test_d1_ramp();
        exp_t e;
        log2_d = 3'd0;
        valid_in = 1'b0;
        tick();
        for (int i = 0; i <= 100; i++) begin
            valid_in = (i < 100);
            x_n = 16'(i);
            tick();
            if (obs_valid && expq.size() != 0) begin
                e = expq.pop_front();
                checks++;
                if (obs_y !== e.value) begin
                    errors++;
                    $display("FAIL d1_model: y_m=%0d, required %0d", obs_y, e.value);
                end
            end
            if (i >= 6) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_y !== 16'(i - 5)) begin
                    errors++;
                    $display("FAIL d1_ramp: valid=%b y_m=%0d, required 1/%0d",
                             obs_valid, obs_y, i - 5);
                end
            end
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL d1_drain: %0d outputs missing, required 0", expq.size());
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        log2_d = 3'd2;
        for (int i = 0; i < 45; i++) begin
            bypass = (i >= 5 && i < 25);
            valid_in = bypass ? ($urandom_range(0, 1) == 1) : (i > 0);
            x_n = bypass ? 16'($urandom) : 16'sd700;
            tick();
            if (bypass) begin
                checks++;
                if (obs_y !== x_n || obs_valid !== valid_in) begin
                    errors++;
                    $display("FAIL bypass: y_m=%0d valid=%b, required %0d/%b",
                             obs_y, obs_valid, x_n, valid_in);
                end
            end else if (obs_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL byp_spurious: valid=1 y_m=%0d, required valid=0", obs_y);
                end else begin
                    e = expq.pop_front();
                    if (obs_y !== e.value) begin
                        errors++;
                        $display("FAIL byp_resume: y_m=%0d, required %0d", obs_y, e.value);
                    end
                end
            end
        end
        bypass = 1'b0;
        valid_in = 1'b0;
        repeat (3) begin
            tick();
            if (obs_valid && expq.size() != 0) void'(expq.pop_front());
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL byp_drain: %0d outputs missing, required 0", expq.size());
        end
    endtask

    task automatic test_en_hold();
        exp_t               e;
        logic signed [15:0] y_hold;
        log2_d = 3'd2;
        for (int i = 0; i < 90; i++) begin
            EN = !(i >= 40 && i < 50);
            valid_in = 1'b1;
            x_n = 16'($urandom);
            if (i == 40) y_hold = obs_y;
            tick();
            if (!EN) begin
                checks++;
                if (obs_valid !== 1'b0 || obs_y !== y_hold) begin
                    errors++;
                    $display("FAIL en_hold: valid=%b y_m=%0d, required 0/%0d",
                             obs_valid, obs_y, y_hold);
                end
            end else if (obs_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL en_spurious: valid=1 y_m=%0d, required valid=0", obs_y);
                end else begin
                    e = expq.pop_front();
                    if (obs_y !== e.value) begin
                        errors++;
                        $display("FAIL en_seq: y_m=%0d, required %0d", obs_y, e.value);
                    end
                end
            end
        end
        EN = 1'b1;
    endtask

    task automatic test_log2_switch();
        exp_t               e;
        int                 nacc = 0;
        bit                 seen = 0;
        logic signed [15:0] last_y = '0;
        log2_d = 3'd2;
        valid_in = 1'b1;
        x_n = 16'sd500;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (obs_valid && expq.size() != 0) void'(expq.pop_front());
        end
        // 14 samples accepted: mid-group; the sample in the switch cycle is dropped.
        log2_d = 3'd3;
        tick();
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL sw_clear: valid=%b, required 0", obs_valid);
        end
        for (int i = 0; i < 200; i++) begin
            int nprev = nacc;
            nacc++;
            tick();
            if (obs_valid) begin
                last_y = obs_y;
                if (!seen) begin
                    seen = 1;
                    checks++;
                    if (nprev != 8) begin
                        errors++;
                        $display("FAIL sw_first: first valid after %0d samples, required 8",
                                 nprev);
                    end
                end
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL sw_spurious: valid=1 y_m=%0d, required valid=0", obs_y);
                end else begin
                    e = expq.pop_front();
                    if (obs_y !== e.value) begin
                        errors++;
                        $display("FAIL sw_out: y_m=%0d, required %0d", obs_y, e.value);
                    end
                end
            end
        end
        checks++;
        if (last_y !== 16'sd500) begin
            errors++;
            $display("FAIL sw_settled: y_m=%0d, required 500", last_y);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        bit   hit = 0;
        log2_d = 3'd2;
        valid_in = 1'b1;
        x_n = 16'sd1000;
        for (int i = 0; i < 60 && !hit; i++) begin
            tick();
            if (obs_valid && expq.size() != 0) begin
                e = expq.pop_front();
                hit = (i > 30) && (obs_y != 0);
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL arst_setup: no nonzero output within budget, required one");
        end
        #2 RST = 1'b0;
        model_clear();
        m_l2d = 0;
        build_h(0);
        #1;
        checks++;
        if (y_m !== 16'sd0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_async: y_m=%0d valid=%b, required 0/0", y_m, valid);
        end
        tick();
        RST = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (obs_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL arst_spurious: valid=1 y_m=%0d, required valid=0", obs_y);
                end else begin
                    e = expq.pop_front();
                    if (obs_y !== e.value) begin
                        errors++;
                        $display("FAIL arst_restart: y_m=%0d, required %0d", obs_y, e.value);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int blk = 0; blk < 6; blk++) begin
            EN = 1'b1;
            bypass = 1'b0;
            valid_in = 1'b0;
            log2_d = 3'($urandom_range(0, 7));
            tick();
            if (obs_valid && expq.size() != 0) void'(expq.pop_front());
            for (int i = 0; i < 250; i++) begin
                x_n = 16'($urandom);
                valid_in = ($urandom_range(0, 3) != 0);
                EN = ($urandom_range(0, 15) != 0);
                bypass = ($urandom_range(0, 19) == 0);
                tick();
                if (!EN) begin
                    checks++;
                    if (obs_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL rnd_en: valid=%b, required 0", obs_valid);
                    end
                end else if (bypass) begin
                    checks++;
                    if (obs_y !== x_n || obs_valid !== valid_in) begin
                        errors++;
                        $display("FAIL rnd_bypass: y_m=%0d valid=%b, required %0d/%b",
                                 obs_y, obs_valid, x_n, valid_in);
                    end
                end else if (obs_valid) begin
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL rnd_spurious: valid=1 y_m=%0d, required valid=0", obs_y);
                    end else begin
                        e = expq.pop_front();
                        if (obs_y !== e.value) begin
                            errors++;
                            $display("FAIL rnd_out: D=%0d y_m=%0d, required %0d",
                                     1 << m_l2d, obs_y, e.value);
                        end
                    end
                end
            end
        end
        EN = 1'b1;
        bypass = 1'b0;
        valid_in = 1'b0;
        repeat (3) begin
            tick();
            if (obs_valid && expq.size() != 0) void'(expq.pop_front());
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain: %0d outputs missing, required 0", expq.size());
        end
    endtask

    initial begin
        build_h(0);
        test_reset();
        test_dc_d4();
        test_extremes();
        test_d1_ramp();
        test_bypass();
        test_en_hold();
        test_log2_switch();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
